cm: RTL and testbench

CM -- requirements
Module: cm

---
 rtl/cm_pkg.sv | 38 +++
 rtl/cm_mul.sv | 23 ++
 rtl/cm.sv | 164 ++++++++++++++++
 tb/tb_cm.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cm_pkg.sv
// cm_pkg: widths, saturation limits and shared types for the ternary-weight
// neuron. Rev 1.0.
`default_nettype none

package cm_pkg;

  localparam int N       = 20;
  localparam int A_W     = 9;
  localparam int W_W     = 2;
  localparam int PROD_W  = 11;
  localparam int SUM_W   = 16;
  localparam int OUT_W   = 13;
  localparam int LEAVES  = 32;

  localparam int SAT_MAX = 4095;
  localparam int SAT_MIN = -4096;

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [SUM_W-1:0]  sum_t;
  typedef logic signed [OUT_W-1:0]  out_t;

  localparam sum_t SUM_SAT_MAX = sum_t'(SAT_MAX);
  localparam sum_t SUM_SAT_MIN = sum_t'(SAT_MIN);

  function automatic out_t saturate(input sum_t s);
    out_t r;
    if (s > SUM_SAT_MAX)
      r = SUM_SAT_MAX[OUT_W-1:0];
    else if (s < SUM_SAT_MIN)
      r = SUM_SAT_MIN[OUT_W-1:0];
    else
      r = s[OUT_W-1:0];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cm_mul.sv
// cm_mul: one combinational signed activation x weight product.
// Rev 1.0.
`default_nettype none

module cm_mul
  import cm_pkg::*;
(
  input  logic signed [A_W-1:0]    a,
  input  logic signed [W_W-1:0]    w,
  output logic signed [PROD_W-1:0] p
);

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] w_ext;

  // Full signed multiply: weight code 2'b10 is simply -2.
  assign a_ext = {{(PROD_W-A_W){a[A_W-1]}}, a};
  assign w_ext = {{(PROD_W-W_W){w[W_W-1]}}, w};
  assign p     = a_ext * w_ext;

endmodule

`default_nettype wire

// File: rtl/cm.sv
// cm: two-stage streaming dot product of 20 activation/weight pairs with
// saturated signed output. Rev 1.0.
`default_nettype none

module cm #(
  parameter int N     = 20,
  parameter int A_W   = 9,
  parameter int W_W   = 2,
  parameter int OUT_W = 13
) (
  input  logic signed [A_W-1:0]   A1,
  input  logic signed [A_W-1:0]   A2,
  input  logic signed [A_W-1:0]   A3,
  input  logic signed [A_W-1:0]   A4,
  input  logic signed [A_W-1:0]   A5,
  input  logic signed [A_W-1:0]   A6,
  input  logic signed [A_W-1:0]   A7,
  input  logic signed [A_W-1:0]   A8,
  input  logic signed [A_W-1:0]   A9,
  input  logic signed [A_W-1:0]   A10,
  input  logic signed [A_W-1:0]   A11,
  input  logic signed [A_W-1:0]   A12,
  input  logic signed [A_W-1:0]   A13,
  input  logic signed [A_W-1:0]   A14,
  input  logic signed [A_W-1:0]   A15,
  input  logic signed [A_W-1:0]   A16,
  input  logic signed [A_W-1:0]   A17,
  input  logic signed [A_W-1:0]   A18,
  input  logic signed [A_W-1:0]   A19,
  input  logic signed [A_W-1:0]   A20,
  input  logic signed [W_W-1:0]   W1,
  input  logic signed [W_W-1:0]   W2,
  input  logic signed [W_W-1:0]   W3,
  input  logic signed [W_W-1:0]   W4,
  input  logic signed [W_W-1:0]   W5,
  input  logic signed [W_W-1:0]   W6,
  input  logic signed [W_W-1:0]   W7,
  input  logic signed [W_W-1:0]   W8,
  input  logic signed [W_W-1:0]   W9,
  input  logic signed [W_W-1:0]   W10,
  input  logic signed [W_W-1:0]   W11,
  input  logic signed [W_W-1:0]   W12,
  input  logic signed [W_W-1:0]   W13,
  input  logic signed [W_W-1:0]   W14,
  input  logic signed [W_W-1:0]   W15,
  input  logic signed [W_W-1:0]   W16,
  input  logic signed [W_W-1:0]   W17,
  input  logic signed [W_W-1:0]   W18,
  input  logic signed [W_W-1:0]   W19,
  input  logic signed [W_W-1:0]   W20,
  input  logic                    clk,
  output logic signed [OUT_W-1:0] out_neuron,
  input  logic                    rst_n
);

  import cm_pkg::*;

  logic signed [A_W-1:0] a_vec [0:N-1];
  logic signed [W_W-1:0] w_vec [0:N-1];
  prod_t                 prod_c [0:N-1];
  prod_t                 prod_r [0:N-1];

  assign a_vec[0]  = A1;
  assign a_vec[1]  = A2;
  assign a_vec[2]  = A3;
  assign a_vec[3]  = A4;
  assign a_vec[4]  = A5;
  assign a_vec[5]  = A6;
  assign a_vec[6]  = A7;
  assign a_vec[7]  = A8;
  assign a_vec[8]  = A9;
  assign a_vec[9]  = A10;
  assign a_vec[10] = A11;
  assign a_vec[11] = A12;
  assign a_vec[12] = A13;
  assign a_vec[13] = A14;
  assign a_vec[14] = A15;
  assign a_vec[15] = A16;
  assign a_vec[16] = A17;
  assign a_vec[17] = A18;
  assign a_vec[18] = A19;
  assign a_vec[19] = A20;

  assign w_vec[0]  = W1;
  assign w_vec[1]  = W2;
  assign w_vec[2]  = W3;
  assign w_vec[3]  = W4;
  assign w_vec[4]  = W5;
  assign w_vec[5]  = W6;
  assign w_vec[6]  = W7;
  assign w_vec[7]  = W8;
  assign w_vec[8]  = W9;
  assign w_vec[9]  = W10;
  assign w_vec[10] = W11;
  assign w_vec[11] = W12;
  assign w_vec[12] = W13;
  assign w_vec[13] = W14;
  assign w_vec[14] = W15;
  assign w_vec[15] = W16;
  assign w_vec[16] = W17;
  assign w_vec[17] = W18;
  assign w_vec[18] = W19;
  assign w_vec[19] = W20;

  generate
    for (genvar i = 0; i < N; i++) begin : g_mul
      cm_mul u_mul (
        .a (a_vec[i]),
        .w (w_vec[i]),
        .p (prod_c[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) prod_r[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) prod_r[i] <= prod_c[i];
    end
  end

  // Balanced 5-level tree over 32 leaves; unused leaves are tied to zero.
  sum_t l0 [0:31];
  sum_t l1 [0:15];
  sum_t l2 [0:7];
  sum_t l3 [0:3];
  sum_t l4 [0:1];
  sum_t l5;

  generate
    for (genvar j = 0; j < LEAVES; j++) begin : g_leaf
      if (j < N) begin : g_live
        assign l0[j] = {{(SUM_W-PROD_W){prod_r[j][PROD_W-1]}}, prod_r[j]};
      end else begin : g_pad
        assign l0[j] = '0;
      end
    end
    for (genvar j = 0; j < 16; j++) begin : g_l1
      assign l1[j] = l0[2*j] + l0[2*j+1];
    end
    for (genvar j = 0; j < 8; j++) begin : g_l2
      assign l2[j] = l1[2*j] + l1[2*j+1];
    end
    for (genvar j = 0; j < 4; j++) begin : g_l3
      assign l3[j] = l2[2*j] + l2[2*j+1];
    end
    for (genvar j = 0; j < 2; j++) begin : g_l4
      assign l4[j] = l3[2*j] + l3[2*j+1];
    end
  endgenerate

  assign l5 = l4[0] + l4[1];

  always_ff @(posedge clk) begin
    if (!rst_n)
      out_neuron <= '0;
    else
      out_neuron <= saturate(l5);
  end

endmodule

`default_nettype wire

// File: tb/tb_cm.sv
// tb_cm: self-checking bench for cm; randomized and directed vectors against
// a delay-line dot-product reference model.
`default_nettype none

module tb_cm;

  logic                clk;
  logic                rst_n;
  logic signed [8:0]   a [20];
  logic signed [1:0]   w [20];
  logic signed [12:0]  out_neuron;

  int total = 0;
  int bad   = 0;

  // Reference: value waiting in stage 1 and the value visible on the output.
  int m_stage = 0;
  int m_out   = 0;

  cm dut (
    .A1(a[0]),   .A2(a[1]),   .A3(a[2]),   .A4(a[3]),   .A5(a[4]),
    .A6(a[5]),   .A7(a[6]),   .A8(a[7]),   .A9(a[8]),   .A10(a[9]),
    .A11(a[10]), .A12(a[11]), .A13(a[12]), .A14(a[13]), .A15(a[14]),
    .A16(a[15]), .A17(a[16]), .A18(a[17]), .A19(a[18]), .A20(a[19]),
    .W1(w[0]),   .W2(w[1]),   .W3(w[2]),   .W4(w[3]),   .W5(w[4]),
    .W6(w[5]),   .W7(w[6]),   .W8(w[7]),   .W9(w[8]),   .W10(w[9]),
    .W11(w[10]), .W12(w[11]), .W13(w[12]), .W14(w[13]), .W15(w[14]),
    .W16(w[15]), .W17(w[16]), .W18(w[17]), .W19(w[18]), .W20(w[19]),
    .clk(clk),
    .out_neuron(out_neuron),
    .rst_n(rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dot();
    int s = 0;
    for (int i = 0; i < 20; i++) s += int'(a[i]) * int'(w[i]);
    return s;
  endfunction

  function automatic int sat(input int s);
    if (s > 4095) return 4095;
    if (s < -4096) return -4096;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_out   = 0;
      m_stage = 0;
    end else begin
      m_out   = sat(m_stage);
      m_stage = dot();
    end
    #1;
  endtask

  task automatic set_all(input int av, input int wv);
    for (int i = 0; i < 20; i++) begin
      a[i] = 9'(av);
      w[i] = 2'(wv);
    end
  endtask

  task automatic set_v1();
    int av [20] = '{0,52,-41,0,-12,115,95,0,5,115,0,52,-41,0,-12,115,95,0,5,-65};
    int wv [20] = '{1,-1,0,0,-1,1,0,-1,1,0,1,-1,0,0,-1,1,0,-1,1,0};
    for (int i = 0; i < 20; i++) begin
      a[i] = 9'(av[i]);
      w[i] = 2'(wv[i]);
    end
  endtask

  task automatic set_single(input int av, input int wv);
    set_all(0, 0);
    a[0] = 9'(av);
    w[0] = 2'(wv);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a[i] = 9'($urandom_range(0, 511));
      w[i] = 2'($urandom_range(0, 3));
    end
    tick();
    tick();
    total++;
    if (int'(out_neuron) !== 0) begin
      bad++;
      $display("FAIL reset_out: got %0d expected 0", out_neuron);
    end
    rst_n = 1'b1;
    set_v1();
    tick();
    total++;
    if (int'(out_neuron) !== 0) begin
      bad++;
      $display("FAIL first_edge_after_reset: got %0d expected 0", out_neuron);
    end
    tick();
    total++;
    if (int'(out_neuron) !== 160) begin
      bad++;
      $display("FAIL v1_result: got %0d expected 160", out_neuron);
    end
  endtask

  task automatic test_directed();
    int av [6] = '{255, -256, -256, 77, 100, 100};
    int wv [6] = '{1,   1,    -2,   0,  -1,  1};
    int ex [6] = '{4095, -4096, 4095, 0, -100, 100};
    for (int k = 0; k < 6; k++) begin
      if (k < 4) set_all(av[k], wv[k]);
      else       set_single(av[k], wv[k]);
      tick();
      tick();
      total++;
      if (int'(out_neuron) !== ex[k]) begin
        bad++;
        $display("FAIL directed_%0d: got %0d expected %0d", k, out_neuron, ex[k]);
      end
      tick();
      total++;
      if (int'(out_neuron) !== ex[k]) begin
        bad++;
        $display("FAIL hold_%0d: got %0d expected %0d", k, out_neuron, ex[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_all(0, 0);
    tick();
    set_v1();
    tick();
    set_single(100, 1);
    tick();
    total++;
    if (int'(out_neuron) !== 160) begin
      bad++;
      $display("FAIL b2b_first: got %0d expected 160", out_neuron);
    end
    set_single(-7, -2);
    tick();
    total++;
    if (int'(out_neuron) !== 100) begin
      bad++;
      $display("FAIL b2b_second: got %0d expected 100", out_neuron);
    end
    tick();
    total++;
    if (int'(out_neuron) !== 14) begin
      bad++;
      $display("FAIL b2b_third: got %0d expected 14", out_neuron);
    end
  endtask

  task automatic test_reset_midstream();
    set_all(0, 0);
    tick();
    set_v1();
    tick();
    rst_n = 1'b0;
    set_all(0, 0);
    tick();
    total++;
    if (int'(out_neuron) !== 0) begin
      bad++;
      $display("FAIL midreset_out: got %0d expected 0", out_neuron);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (int'(out_neuron) !== 0) begin
        bad++;
        $display("FAIL midreset_flush_%0d: got %0d expected 0", k, out_neuron);
      end
    end
    set_v1();
    tick();
    tick();
    total++;
    if (int'(out_neuron) !== 160) begin
      bad++;
      $display("FAIL midreset_reapply: got %0d expected 160", out_neuron);
    end
  endtask

  task automatic test_random();
    int mode;
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 29) != 0);
      mode  = $urandom_range(0, 3);
      for (int i = 0; i < 20; i++) begin
        if (mode == 0) begin
          a[i] = 9'($urandom_range(200, 255));
          w[i] = 2'(1);
        end else if (mode == 1) begin
          a[i] = 9'(-int'($urandom_range(200, 256)));
          w[i] = 2'($urandom_range(0, 1) ? 1 : 0);
        end else begin
          a[i] = 9'($urandom_range(0, 511));
          w[i] = 2'($urandom_range(0, 3));
        end
      end
      tick();
      total++;
      if (int'(out_neuron) !== m_out) begin
        bad++;
        $display("FAIL random_%0d: got %0d expected %0d", c, out_neuron, m_out);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_all(0, 0);
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
